// File: rtl/alu_wb_if.sv
// Handshake and register-file write bundle between decode/control, the
// execute/writeback stage and the register file write port.
// master: issue side (start, op, operands, rd in; ready and write port out).
// slave:  the alu_wb_stage itself.
interface alu_wb_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
);
    logic              start;
    logic [2:0]        op;
    logic [WIDTH-1:0]  rs1_val;
    logic [WIDTH-1:0]  rs2_val;
    logic [ADDR_W-1:0] rd;
    logic              ready;
    logic              wr_en;
    logic [ADDR_W-1:0] write_addr;
    logic [WIDTH-1:0]  write_val;
    logic              carry;
    logic              zero;

    modport master (
        output start, op, rs1_val, rs2_val, rd,
        input  ready, wr_en, write_addr, write_val, carry, zero
    );

    modport slave (
        input  start, op, rs1_val, rs2_val, rd,
        output ready, wr_en, write_addr, write_val, carry, zero
    );
endinterface

// File: rtl/alu_wb_stage.sv
// Execute/writeback stage: single-cycle ALU ops or an iterative shift-add
// multiply, writing the result to the register file for exactly one cycle.
// Ports: clk, reset (async, active-high) and bus (alu_wb_if.slave): start/op/
//   rs1_val/rs2_val/rd in; ready, wr_en/write_addr/write_val, carry/zero out.
// Latency: ALU op write one cycle after accept, MUL/MULH after MUL_CYCLES+1.
// Backpressure: ready is high only in IDLE; start while busy is dropped.
// Option: define ALU_WB_R0_GUARD_EN to suppress wr_en for rd=0 (r0 read-only).
module alu_wb_stage #(
    parameter int WIDTH      = 8,
    parameter int ADDR_W     = 3,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic   clk,
    input  logic   reset,
    alu_wb_if.slave bus
);
    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t              state_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   write_addr_q;
    logic [WIDTH-1:0]    write_val_q;
    logic                carry_q;
    logic                zero_q;

    // Multiplier state: operands are latched so the issue side may change
    // its inputs freely while the multiply is in flight.
    logic                mulh_q;
    logic [ADDR_W-1:0]   rd_q;
    logic [WIDTH-1:0]    mplier_q;
    logic [WIDTH-1:0]    mcand_q;
    logic [2*WIDTH-1:0]  acc_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [WIDTH-1:0]    alu_res_d;
    logic                alu_cry_d;
    logic [WIDTH:0]      sum_d;
    logic [WIDTH:0]      diff_d;
    logic [2*WIDTH-1:0]  acc_d;
    logic [WIDTH-1:0]    mul_res_d;
    logic                alu_wen_d;
    logic                mul_wen_d;

    always_comb begin
        sum_d     = {1'b0, bus.rs1_val} + {1'b0, bus.rs2_val};
        diff_d    = {1'b0, bus.rs1_val} - {1'b0, bus.rs2_val};
        alu_res_d = '0;
        alu_cry_d = 1'b0;
        case (bus.op)
            3'b000: begin alu_res_d = sum_d[WIDTH-1:0];  alu_cry_d = sum_d[WIDTH];  end
            // Borrow falls out as the extra top bit of the widened subtract.
            3'b001: begin alu_res_d = diff_d[WIDTH-1:0]; alu_cry_d = diff_d[WIDTH]; end
            3'b010: alu_res_d = bus.rs1_val & bus.rs2_val;
            3'b011: alu_res_d = bus.rs1_val ^ bus.rs2_val;
            3'b100: alu_res_d = bus.rs1_val << bus.rs2_val[2:0];
            3'b101: alu_res_d = bus.rs1_val >> bus.rs2_val[2:0];
            default: alu_res_d = '0;   // MUL/MULH handled by the iterative path
        endcase

        // Add the multiplicand aligned to the bit currently being examined.
        acc_d     = acc_q + (mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q)
                                         : {2*WIDTH{1'b0}});
        mul_res_d = mulh_q ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];

`ifdef ALU_WB_R0_GUARD_EN
        alu_wen_d = (bus.rd != '0);
        mul_wen_d = (rd_q != '0);
`else
        alu_wen_d = 1'b1;
        mul_wen_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wr_en_q      <= 1'b0;
            write_addr_q <= '0;
            write_val_q  <= '0;
            carry_q      <= 1'b0;
            zero_q       <= 1'b0;
            mulh_q       <= 1'b0;
            rd_q         <= '0;
            mplier_q     <= '0;
            mcand_q      <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wr_en_q <= 1'b0;
                    if (bus.start) begin
                        mulh_q   <= bus.op[0];
                        rd_q     <= bus.rd;
                        mplier_q <= bus.rs1_val;
                        mcand_q  <= bus.rs2_val;
                        if (bus.op[2:1] == 2'b11) begin
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= ST_MUL;
                        end else begin
                            // Outputs are registered on entry to WB so they
                            // are valid throughout the WB cycle.
                            write_val_q  <= alu_res_d;
                            write_addr_q <= bus.rd;
                            carry_q      <= alu_cry_d;
                            zero_q       <= (alu_res_d == '0);
                            wr_en_q      <= alu_wen_d;
                            state_q      <= ST_WB;
                        end
                    end
                end
                ST_MUL: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    // Final iteration result goes straight into the output
                    // registers, so WB follows the last iteration directly.
                    if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
                        write_val_q  <= mul_res_d;
                        write_addr_q <= rd_q;
                        carry_q      <= 1'b0;
                        zero_q       <= (mul_res_d == '0);
                        wr_en_q      <= mul_wen_d;
                        state_q      <= ST_WB;
                    end
                end
                ST_WB: begin
                    wr_en_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    wr_en_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready      = (state_q == ST_IDLE);
    assign bus.wr_en      = wr_en_q;
    assign bus.write_addr = write_addr_q;
    assign bus.write_val  = write_val_q;
    assign bus.carry      = carry_q;
    assign bus.zero       = zero_q;
endmodule

// File: tb/tb_alu_wb_stage.sv
module tb_alu_wb_stage;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    alu_wb_if #(.WIDTH(8), .ADDR_W(3)) bus ();

    alu_wb_stage #(.WIDTH(8), .ADDR_W(3), .MUL_CYCLES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                           OP_XOR = 3'b011, OP_SLL = 3'b100, OP_SRL = 3'b101,
                           OP_MUL = 3'b110, OP_MULH = 3'b111;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present an op at a falling edge; it is accepted at the next rising edge.
    // Returns at the falling edge after acceptance (first cycle after accept).
    task automatic issue(input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] rd);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs1_val = a;
        bus.rs2_val = b;
        bus.rd      = rd;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.rs1_val = 8'hA5;   // operands must not matter after accept
        bus.rs2_val = 8'h5A;
    endtask

    // Observe 12 cycles after a multiply issue, optionally pulsing an ADD
    // start at cycles 3 and 9 (both while the stage is busy).
    task automatic mul_watch(input bit inject, output int wen_cnt, output int wen_k,
                             output int busy_cnt, output logic [7:0] val,
                             output logic [2:0] addr, output logic cry);
        wen_cnt = 0; wen_k = 0; busy_cnt = 0; val = '0; addr = '0; cry = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (bus.wr_en) begin
                wen_cnt++; wen_k = k; val = bus.write_val;
                addr = bus.write_addr; cry = bus.carry;
            end
            if (!bus.ready) busy_cnt++;
            if (inject && (k == 3 || k == 9)) begin
                bus.start = 1'b1; bus.op = OP_ADD;
                bus.rs1_val = 8'h01; bus.rs2_val = 8'h01; bus.rd = 3'd6;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    int          wc, wk, bc;
    logic [7:0]  wv;
    logic [2:0]  wa;
    logic        wcy;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.start = 1'b0; bus.op = '0; bus.rs1_val = '0; bus.rs2_val = '0; bus.rd = '0;
        repeat (2) @(negedge clk);
        check("rst_wr_en", 16'(bus.wr_en), 16'h0);
        check("rst_addr",  16'(bus.write_addr), 16'h0);
        check("rst_val",   16'(bus.write_val), 16'h0);
        check("rst_carry", 16'(bus.carry), 16'h0);
        check("rst_zero",  16'(bus.zero), 16'h0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 16'(bus.ready), 16'h1);

        // ADD with carry out
        issue(OP_ADD, 8'hF0, 8'h20, 3'd5);
        check("add_wen",   16'(bus.wr_en), 16'h1);
        check("add_addr",  16'(bus.write_addr), 16'h5);
        check("add_val",   16'(bus.write_val), 16'h10);
        check("add_carry", 16'(bus.carry), 16'h1);
        check("add_zero",  16'(bus.zero), 16'h0);
        check("add_busy",  16'(bus.ready), 16'h0);
        @(negedge clk);
        check("add_wen_drop", 16'(bus.wr_en), 16'h0);
        check("add_ready",    16'(bus.ready), 16'h1);
        check("add_carry_hold", 16'(bus.carry), 16'h1);

        issue(OP_SUB, 8'h05, 8'h05, 3'd2);
        check("sub0_val",   16'(bus.write_val), 16'h00);
        check("sub0_zero",  16'(bus.zero), 16'h1);
        check("sub0_carry", 16'(bus.carry), 16'h0);
        check("sub0_addr",  16'(bus.write_addr), 16'h2);
        @(negedge clk);
        issue(OP_SUB, 8'h03, 8'h04, 3'd3);
        check("subb_val",   16'(bus.write_val), 16'hFF);
        check("subb_carry", 16'(bus.carry), 16'h1);
        check("subb_zero",  16'(bus.zero), 16'h0);
        @(negedge clk);
        issue(OP_AND, 8'hF0, 8'h3C, 3'd1);
        check("and_val",   16'(bus.write_val), 16'h30);
        check("and_carry", 16'(bus.carry), 16'h0);
        @(negedge clk);
        issue(OP_XOR, 8'hF0, 8'h3C, 3'd1);
        check("xor_val", 16'(bus.write_val), 16'hCC);
        @(negedge clk);
        issue(OP_SRL, 8'h81, 8'h0B, 3'd1);
        check("srl_val", 16'(bus.write_val), 16'h10);
        @(negedge clk);

        // MUL 0x0D*0x0B = 0x008F
        issue(OP_MUL, 8'h0D, 8'h0B, 3'd7);
        mul_watch(1'b0, wc, wk, bc, wv, wa, wcy);
        check("mul_wen_cnt", 16'(wc), 16'd1);
        check("mul_wen_cyc", 16'(wk), 16'd9);
        check("mul_busy",    16'(bc), 16'd9);
        check("mul_val",     16'(wv), 16'h8F);
        check("mul_addr",    16'(wa), 16'h7);

        // MULH 0xFF*0xFF = 0xFE01, carry set beforehand to see it cleared
        issue(OP_ADD, 8'hFF, 8'h01, 3'd1);
        @(negedge clk);
        issue(OP_MULH, 8'hFF, 8'hFF, 3'd2);
        mul_watch(1'b0, wc, wk, bc, wv, wa, wcy);
        check("mulh_wen_cnt", 16'(wc), 16'd1);
        check("mulh_val",     16'(wv), 16'hFE);
        check("mulh_carry",   16'(wcy), 16'h0);

        // Starts while busy are dropped; 0x03*0x05 = 0x0F
        issue(OP_MUL, 8'h03, 8'h05, 3'd4);
        mul_watch(1'b1, wc, wk, bc, wv, wa, wcy);
        check("ign_wen_cnt", 16'(wc), 16'd1);
        check("ign_wen_cyc", 16'(wk), 16'd9);
        check("ign_val",     16'(wv), 16'h0F);
        check("ign_addr",    16'(wa), 16'h4);
        check("ign_ready",   16'(bus.ready), 16'h1);

        // Reset in the middle of a multiply
        issue(OP_MUL, 8'h0D, 8'h0B, 3'd7);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mrst_wen",  16'(bus.wr_en), 16'h0);
        check("mrst_val",  16'(bus.write_val), 16'h0);
        check("mrst_addr", 16'(bus.write_addr), 16'h0);
        check("mrst_zero", 16'(bus.zero), 16'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mrst_ready", 16'(bus.ready), 16'h1);
        mul_watch(1'b0, wc, wk, bc, wv, wa, wcy);
        check("mrst_no_wen", 16'(wc), 16'd0);
        issue(OP_ADD, 8'h01, 8'h01, 3'd3);
        check("mrst_add_val", 16'(bus.write_val), 16'h02);
        check("mrst_add_wen", 16'(bus.wr_en), 16'h1);
        @(negedge clk);

        // SLL to r0, shift amount from B[2:0]
        issue(OP_SLL, 8'h81, 8'h09, 3'd0);
        check("sll_val",   16'(bus.write_val), 16'h02);
        check("sll_carry", 16'(bus.carry), 16'h0);
        check("sll_addr",  16'(bus.write_addr), 16'h0);
`ifdef ALU_WB_R0_GUARD_EN
        check("sll_r0_wen", 16'(bus.wr_en), 16'h0);
`else
        check("sll_r0_wen", 16'(bus.wr_en), 16'h1);
`endif
        @(negedge clk);
        check("sll_ready", 16'(bus.ready), 16'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
